decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  Registered, flow-controlled successor to the combinational decoder. Accepts one instruction per cycle
//  over valid/ready, decodes LOAD/STORE/MOVE/MAC fields and enables, and holds results in one output register.
//  Tracks in-flight register writes with a scoreboard and stalls on RAW/WAW hazards until writeback clears them.
//  Sits between fetch and the register-file/MAC execute stage.
// PARAMETERS
//  REG_ADDR_WIDTH  4   register address width; NUM_REGS = 2**REG_ADDR_WIDTH
//  ISA_WIDTH       16  instruction width; must equal 3*REG_ADDR_WIDTH+4 (elaboration error otherwise)
//  IMM_S_WIDTH     REG_ADDR_WIDTH+1    short immediate (LOAD offset), 5 by default
//  IMM_L_WIDTH     2*REG_ADDR_WIDTH+1  long immediate (MOVE), 9 by default
// PORTS
//  clk        in   1    clock
//  rst        in   1    synchronous active-high reset
//  flush      in   1    drop held instruction (synchronous)
//  in_valid   in   1    instruction offered
//  in_ready   out  1    instruction accepted this cycle when in_valid&in_ready
//  in_inst    in   ISA_WIDTH  instruction word
//  out_valid  out  1    decoded instruction held
//  out_ready  in   1    execute consumes when out_valid&out_ready
//  opcode     out  3    inst[MSB -: 3]
//  rd_addr/rs1_addr/rs2_addr  out  REG_ADDR_WIDTH each  register fields
//  imm5       out  IMM_S_WIDTH   LOAD immediate
//  imm9       out  IMM_L_WIDTH   MOVE immediate
//  funct      out  1    MAC mode: 1 = accumulate into rd
//  reg_wen / mem_wen / mac_en  out  1 each  write-reg, write-mem, MAC enables
//  illegal    out  1    opcode 100..111
//  wb_valid   in   1    writeback retiring a register write
//  wb_addr    in   REG_ADDR_WIDTH  register being written back
// BEHAVIOUR
//  Fields, MSB first: opcode[3] | rd[RAW] | rs1[RAW] | rs2[RAW] | funct[1]; imm5 = low IMM_S bits, imm9 = low IMM_L bits.
//  Opcodes: LOAD 000, STORE 001, MOVE 010, MAC 011.
//  Zeroing: STORE rd=0; MOVE rs1=0; rs2 valid only for STORE/MAC, else 0; imm5 LOAD only, imm9 MOVE only, funct MAC only, else 0.
//  Enables: reg_wen=1 for LOAD/MOVE/MAC; mem_wen=1 for STORE only; mac_en=1 for MAC only.
//  Illegal opcode: illegal=1, all fields and enables 0, no scoreboard update, still passes through handshake.
//  Sources read: LOAD rs1; STORE rs1,rs2; MOVE none; MAC rs1,rs2, plus rd when funct=1.
//  hazard = any read source busy OR (reg_wen AND busy[rd]). Uses registered busy only, no same-cycle wb bypass.
//  in_ready = !rst & !flush & !hazard & (!out_valid | out_ready). Combinational on in_inst; in_ready never depends on in_valid.
//  Accept: output register loads next edge, out_valid=1; latency 1 cycle. Back-to-back issue when out_ready=1.
//  Stall: out_valid&!out_ready holds all outputs stable. A consume with no accept leaves out_valid=0 next cycle.
//  Scoreboard busy[NUM_REGS]: set busy[rd] on accept when reg_wen; clear busy[wb_addr] on wb_valid.
//    Same address set+clear in one cycle: set wins.
//  flush: out_valid<=0 next edge. If the held instruction had reg_wen, busy[its rd] is cleared, unless a wb set on
//    the same address happens that cycle. No accept during flush. Other busy bits are kept.
//  rst: out_valid=0, all field/enable outputs 0, busy all 0; in_ready=0 while rst high.
//  wb_valid for a non-busy register is a no-op.
// STRUCTURE
//  decode_defs.vh (shared include): opcode localparams, field-offset macros derived from REG_ADDR_WIDTH.
//  Sub-module reg_scoreboard: busy vector, set/clear ports, and two read ports plus rd port returning busy bits.
//  Combinational field decode and output register live in decode_stage.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> out_valid=0, all outputs 0, in_ready=0; after release in_ready=1.
//  2 LOAD 16'h0645 with out_ready=1 -> next cycle rd=3, rs1=2, imm5=5, reg_wen=1, mem_wen=0; busy[3] set.
//  3 RAW: after 0x0645, offer MAC 16'h6863 (rd4, rs1 3, rs2 1, funct1) -> in_ready=0.
//    Assert wb_valid, wb_addr=3 -> accepted the cycle after the clear; mac_en=1, funct=1.
//  4 Backpressure: MOVE 16'h4BFF accepted with out_ready=0 for 3 cycles -> outputs held, imm9=9'h1FF, rs1=0, in_ready=0.
//  5 Illegal 16'hE000 -> illegal=1, all enables 0, scoreboard unchanged.
//    Flush while holding 0x0645 -> out_valid=0 and busy[3]=0.
//  6 Same-cycle wb_addr=5 with accept of MOVE to r5 -> busy[5]=1; random stream vs. reference model: no hazard violated.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: opcode encodings and opcode helpers.
package decode_stage_pkg;

  localparam int OPCODE_WIDTH = 3;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_MOVE  = 3'b010,
    OP_MAC   = 3'b011
  } opcode_e;

  // Opcodes 100..111 are reserved; only the top bit distinguishes them.
  function automatic logic opcode_legal(input logic [OPCODE_WIDTH-1:0] op);
    return (op[OPCODE_WIDTH-1] == 1'b0);
  endfunction

endpackage

// File: rtl/decode_stage_scoreboard.sv
// Register busy scoreboard: one busy bit per architectural register, set when a
// register-writing instruction issues, cleared by writeback or by a flushed writer.
module decode_stage_scoreboard #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  wb_clr_en,
  input  logic [ADDR_WIDTH-1:0] wb_clr_addr,
  input  logic                  flush_clr_en,
  input  logic [ADDR_WIDTH-1:0] flush_clr_addr,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rd_busy
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;

  // Per-register next state: a set in the same cycle as any clear wins.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
    logic hit_set;
    logic hit_clr;
    assign hit_set = set_en && (set_addr == ADDR_WIDTH'(gi));
    assign hit_clr = (wb_clr_en && (wb_clr_addr == ADDR_WIDTH'(gi))) ||
                     (flush_clr_en && (flush_clr_addr == ADDR_WIDTH'(gi)));
    assign busy_next[gi] = hit_set | (busy_reg[gi] & ~hit_clr);
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  // Read ports see registered state only; no bypass of this cycle's writeback.
  assign rs1_busy = busy_reg[rs1_addr];
  assign rs2_busy = busy_reg[rs2_addr];
  assign rd_busy  = busy_reg[rd_addr];

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready input, single output register, and
// scoreboard-based stall on RAW/WAW hazards against in-flight register writes.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int ISA_WIDTH      = 16,
  parameter int IMM_S_WIDTH    = REG_ADDR_WIDTH + 1,
  parameter int IMM_L_WIDTH    = 2 * REG_ADDR_WIDTH + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ISA_WIDTH-1:0]      in_inst,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPCODE_WIDTH-1:0]   opcode,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic [IMM_S_WIDTH-1:0]    imm5,
  output logic [IMM_L_WIDTH-1:0]    imm9,
  output logic                      funct,
  output logic                      reg_wen,
  output logic                      mem_wen,
  output logic                      mac_en,
  output logic                      illegal,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr
);

  if (ISA_WIDTH != 3 * REG_ADDR_WIDTH + 4) begin : g_width_check
    $error("decode_stage: ISA_WIDTH must equal 3*REG_ADDR_WIDTH+4");
  end

  // Field positions, MSB first: opcode | rd | rs1 | rs2 | funct.
  localparam int RD_LSB  = ISA_WIDTH - OPCODE_WIDTH - REG_ADDR_WIDTH;
  localparam int RS1_LSB = RD_LSB - REG_ADDR_WIDTH;
  localparam int RS2_LSB = RS1_LSB - REG_ADDR_WIDTH;

  logic [OPCODE_WIDTH-1:0]   dec_op;
  logic [REG_ADDR_WIDTH-1:0] dec_rd, dec_rs1, dec_rs2;
  logic [IMM_S_WIDTH-1:0]    dec_imm5;
  logic [IMM_L_WIDTH-1:0]    dec_imm9;
  logic dec_funct, dec_reg_wen, dec_mem_wen, dec_mac_en, dec_illegal;
  logic use_rs1, use_rs2, use_rd;
  logic rs1_busy, rs2_busy, rd_busy;
  logic hazard, accept;

  logic [OPCODE_WIDTH-1:0]   opcode_reg;
  logic [REG_ADDR_WIDTH-1:0] rd_reg, rs1_reg, rs2_reg;
  logic [IMM_S_WIDTH-1:0]    imm5_reg;
  logic [IMM_L_WIDTH-1:0]    imm9_reg;
  logic funct_reg, reg_wen_reg, mem_wen_reg, mac_en_reg, illegal_reg, out_valid_reg;

  assign dec_op = in_inst[ISA_WIDTH-1 -: OPCODE_WIDTH];

  // Field decode with per-opcode zeroing, enables and the set of registers read.
  always_comb begin
    dec_rd      = '0;
    dec_rs1     = '0;
    dec_rs2     = '0;
    dec_imm5    = '0;
    dec_imm9    = '0;
    dec_funct   = 1'b0;
    dec_reg_wen = 1'b0;
    dec_mem_wen = 1'b0;
    dec_mac_en  = 1'b0;
    dec_illegal = !opcode_legal(dec_op);
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    use_rd      = 1'b0;
    case (dec_op)
      OP_LOAD: begin
        dec_rd      = in_inst[RD_LSB +: REG_ADDR_WIDTH];
        dec_rs1     = in_inst[RS1_LSB +: REG_ADDR_WIDTH];
        dec_imm5    = in_inst[IMM_S_WIDTH-1:0];
        dec_reg_wen = 1'b1;
        use_rs1     = 1'b1;
      end
      OP_STORE: begin
        dec_rs1     = in_inst[RS1_LSB +: REG_ADDR_WIDTH];
        dec_rs2     = in_inst[RS2_LSB +: REG_ADDR_WIDTH];
        dec_mem_wen = 1'b1;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
      end
      OP_MOVE: begin
        dec_rd      = in_inst[RD_LSB +: REG_ADDR_WIDTH];
        dec_imm9    = in_inst[IMM_L_WIDTH-1:0];
        dec_reg_wen = 1'b1;
      end
      OP_MAC: begin
        dec_rd      = in_inst[RD_LSB +: REG_ADDR_WIDTH];
        dec_rs1     = in_inst[RS1_LSB +: REG_ADDR_WIDTH];
        dec_rs2     = in_inst[RS2_LSB +: REG_ADDR_WIDTH];
        dec_funct   = in_inst[0];
        dec_reg_wen = 1'b1;
        dec_mac_en  = 1'b1;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        use_rd      = in_inst[0];
      end
      default: ;
    endcase
  end

  decode_stage_scoreboard #(
    .ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .set_en        (accept && dec_reg_wen),
    .set_addr      (dec_rd),
    .wb_clr_en     (wb_valid),
    .wb_clr_addr   (wb_addr),
    .flush_clr_en  (flush && out_valid_reg && reg_wen_reg),
    .flush_clr_addr(rd_reg),
    .rs1_addr      (dec_rs1),
    .rs2_addr      (dec_rs2),
    .rd_addr       (dec_rd),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .rd_busy       (rd_busy)
  );

  // A write target that is still busy is a WAW hazard, same as a busy source.
  assign hazard   = (use_rs1 && rs1_busy) || (use_rs2 && rs2_busy) ||
                    ((use_rd || dec_reg_wen) && rd_busy);
  assign in_ready = !rst && !flush && !hazard && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  // Output register: load on accept, drop on flush or on a consume without a refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      opcode_reg    <= '0;
      rd_reg        <= '0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      imm5_reg      <= '0;
      imm9_reg      <= '0;
      funct_reg     <= 1'b0;
      reg_wen_reg   <= 1'b0;
      mem_wen_reg   <= 1'b0;
      mac_en_reg    <= 1'b0;
      illegal_reg   <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      opcode_reg    <= dec_op;
      rd_reg        <= dec_rd;
      rs1_reg       <= dec_rs1;
      rs2_reg       <= dec_rs2;
      imm5_reg      <= dec_imm5;
      imm9_reg      <= dec_imm9;
      funct_reg     <= dec_funct;
      reg_wen_reg   <= dec_reg_wen;
      mem_wen_reg   <= dec_mem_wen;
      mac_en_reg    <= dec_mac_en;
      illegal_reg   <= dec_illegal;
    end else if (flush || out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign opcode    = opcode_reg;
  assign rd_addr   = rd_reg;
  assign rs1_addr  = rs1_reg;
  assign rs2_addr  = rs2_reg;
  assign imm5      = imm5_reg;
  assign imm9      = imm9_reg;
  assign funct     = funct_reg;
  assign reg_wen   = reg_wen_reg;
  assign mem_wen   = mem_wen_reg;
  assign mac_en    = mac_en_reg;
  assign illegal   = illegal_reg;

endmodule
